// File: rtl/seq_match_sched.sv
// -----------------------------------------------------------------------------
// seq_match_sched
//
// Serializes DATA_W-bit words (accepted on a valid/ready handshake) MSB-first
// into a one-bit-per-cycle stream, and runs a programmable PAT_W-bit
// Moore-style pattern detector over that stream. Matches are counted, with the
// count saturating at all-ones. Overlapping or non-overlapping matching is
// chosen per job.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset (0 = reset)
//   start        begin a job; only looked at while idle
//   cfg_pattern  pattern to detect, MSB is the first stream bit
//   cfg_overlap  1 = overlapping matches allowed
//   in_valid     producer word valid
//   in_data      producer word, sent MSB first
//   in_last      marks the final word of the job (qualified by in_valid)
//   in_ready     controller can take a word this cycle
//   bit_valid    bit_out carries a live stream bit
//   bit_out      current stream bit
//   match        one-cycle pulse, one cycle after the completing bit
//   match_count  saturating match count for the current job
//   busy         high whenever a job is in progress
//   done         one-cycle pulse at the end of a job
// -----------------------------------------------------------------------------
module seq_match_sched #(
  parameter int PAT_W  = 5,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              bit_valid,
  output logic              bit_out,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int FILL_W = $clog2(PAT_W);
  localparam int HIST_W = PAT_W - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic                ovl_q, ovl_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                last_q, last_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [HIST_W-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                match_q, match_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                clr_job;
  logic [PAT_W-1:0]    cand;
  logic                fill_full;
  logic                hit;

  // Saturating increment for the match counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Sequencer: IDLE -> WAIT -> SHIFT (DATA_W cycles) -> WAIT ... -> DONE
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    ovl_d     = ovl_q;
    word_d    = word_q;
    last_d    = last_q;
    idx_d     = idx_q;
    clr_job   = 1'b0;
    in_ready  = 1'b0;
    bit_valid = 1'b0;
    bit_out   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          pat_d   = cfg_pattern;
          ovl_d   = cfg_overlap;
          clr_job = 1'b1;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d  = in_data;
          last_d  = in_last;
          idx_d   = IDX_W'(DATA_W - 1);
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        bit_valid = 1'b1;
        bit_out   = word_q[idx_q];
        if (idx_q == '0) begin
          // Returning to WAIT costs one bubble cycle between words.
          state_d = last_q ? S_DONE : S_WAIT;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Matcher: candidate window is the last PAT_W-1 bits plus the live bit
  // ---------------------------------------------------------------------------
  always_comb begin
    cand      = {hist_q, bit_out};
    fill_full = (fill_q == FILL_W'(PAT_W - 1));
    hit       = bit_valid && fill_full && (cand == pat_q);

    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    match_d = hit;

    if (clr_job) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (bit_valid) begin
      // History and fill only move on live bits, so a pattern may straddle
      // word boundaries, bubbles and producer stalls.
      hist_d = cand[HIST_W-1:0];
      if (hit) begin
        cnt_d = sat_inc(cnt_q);
        // Non-overlap: the next match must be built from PAT_W fresh bits.
        if (!ovl_q) begin
          fill_d = '0;
        end
      end else if (!fill_full) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      word_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      word_q  <= word_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_match_sched.sv
// -----------------------------------------------------------------------------
// tb_seq_match_sched
//
// Drives directed and random jobs into two copies of seq_match_sched (match
// counter 8 bits wide and 2 bits wide). A job-level model built from the
// stream of words (list of stream bits, window scan, saturating counts) is
// compared with the outputs on every falling edge.
// -----------------------------------------------------------------------------
module tb_seq_match_sched;

  localparam int PAT_W  = 5;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic [PAT_W-1:0]  cfg_pattern;
  logic              cfg_overlap;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  logic              in_ready, bit_valid, bit_out, match, busy, done;
  logic [7:0]        match_count;
  logic              s_in_ready, s_bit_valid, s_bit_out, s_match, s_busy, s_done;
  logic [1:0]        s_match_count;

  seq_match_sched #(.PAT_W(PAT_W), .DATA_W(DATA_W), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .bit_valid(bit_valid),
    .bit_out(bit_out), .match(match), .match_count(match_count),
    .busy(busy), .done(done)
  );

  seq_match_sched #(.PAT_W(PAT_W), .DATA_W(DATA_W), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(s_in_ready), .bit_valid(s_bit_valid),
    .bit_out(s_bit_out), .match(s_match), .match_count(s_match_count),
    .busy(s_busy), .done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Job-level model
  // ---------------------------------------------------------------------------
  bit               bits[$];      // every stream bit of the current job
  int               elig;         // first bit index that may start a match
  logic [PAT_W-1:0] m_pat;
  logic             m_ovl;
  logic             m_busy, m_wait, m_last;
  int               m_left;       // bits still to stream from m_word
  logic [DATA_W-1:0] m_word;
  logic             n_hit, n_done;  // expectations for the current cycle
  logic [7:0]       cnt8;
  logic [1:0]       cnt2;

  // Per-job records for the directed literal checks.
  int               cyc, t_start, t_match, t_done, pulses;
  logic [7:0]       done_cnt;
  logic [1:0]       done_cnt2;

  always @(negedge clk) begin
    logic             nh, nd, b;
    logic [PAT_W-1:0] w;
    cyc++;
    if (!rst) begin
      bits.delete();
      elig = 0; m_busy = 0; m_wait = 0; m_last = 0; m_left = 0;
      n_hit = 0; n_done = 0; cnt8 = 0; cnt2 = 0;
    end else begin
      if (n_hit) begin
        if (cnt8 != 8'hFF) cnt8 = cnt8 + 8'd1;
        if (cnt2 != 2'b11) cnt2 = cnt2 + 2'd1;
      end
      chk("match", 32'(match), 32'(n_hit));
      chk("match_count", 32'(match_count), 32'(cnt8));
      chk("sat_match", 32'(s_match), 32'(n_hit));
      chk("sat_match_count", 32'(s_match_count), 32'(cnt2));
      chk("done", 32'(done), 32'(n_done));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("in_ready", 32'(in_ready), 32'(m_wait));
      chk("bit_valid", 32'(bit_valid), 32'(m_left != 0));
      if (m_left != 0) chk("bit_out", 32'(bit_out), 32'(m_word[m_left-1]));

      if (match) begin
        pulses++;
        if (t_match < 0) t_match = cyc;
      end
      if (done) begin
        t_done = cyc; done_cnt = match_count; done_cnt2 = s_match_count;
      end

      nh = 0; nd = 0;
      if (m_left != 0) begin
        b = m_word[m_left-1];
        bits.push_back(b);
        if (bits.size() - elig >= PAT_W) begin
          w = '0;
          for (int k = 0; k < PAT_W; k++)
            w = {w[PAT_W-2:0], bits[bits.size() - PAT_W + k]};
          if (w == m_pat) begin
            nh = 1;
            if (!m_ovl) elig = bits.size();
          end
        end
        m_left--;
        if (m_left == 0) begin
          if (m_last) nd = 1;
          else        m_wait = 1;
        end
      end else if (m_wait && in_valid) begin
        m_wait = 0; m_left = DATA_W; m_word = in_data; m_last = in_last;
      end else if (!m_busy && start) begin
        m_pat = cfg_pattern; m_ovl = cfg_overlap;
        bits.delete(); elig = 0; cnt8 = 0; cnt2 = 0;
        m_busy = 1; m_wait = 1;
        t_start = cyc; t_match = -1; pulses = 0;
      end
      if (n_done) m_busy = 0;
      n_hit = nh; n_done = nd;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all driving at 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic junk();
    start       = ($urandom_range(0, 3) == 0);
    cfg_pattern = PAT_W'($urandom);
    cfg_overlap = 1'($urandom);
  endtask

  task automatic begin_job(input logic [PAT_W-1:0] p, input logic o);
    @(posedge clk); #1;
    start = 1; cfg_pattern = p; cfg_overlap = o;
    @(posedge clk); #1;
    start = 0; cfg_pattern = PAT_W'($urandom); cfg_overlap = 1'($urandom);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input logic l, input int gap);
    int n;
    repeat (gap) begin @(posedge clk); #1; junk(); end
    in_valid = 1; in_data = d; in_last = l;
    n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; junk(); n++; end
    chk("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 0; in_data = DATA_W'($urandom); in_last = 1'($urandom); start = 0;
  endtask

  task automatic end_job();
    int n;
    n = 0;
    while (!done && n < 200) begin @(posedge clk); #1; n++; end
    chk("done_timeout", 32'(done), 32'd1);
    @(negedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 0; start = 0; cfg_pattern = '0; cfg_overlap = 0;
    in_valid = 0; in_data = '0; in_last = 0;
    cyc = 0; t_start = 0; t_match = -1; t_done = 0; pulses = 0;
    done_cnt = 0; done_cnt2 = 0;
    #3;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_bit_valid", 32'(bit_valid), 0);
    chk("rst_bit_out", 32'(bit_out), 0);
    chk("rst_match", 32'(match), 0);
    chk("rst_match_count", 32'(match_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;

    // Single word, pattern at the front.
    begin_job(5'b10011, 0);
    send_word(8'h99, 1, 0);
    end_job();
    chk("t1_done_latency", 32'(t_done - t_start), 32'd10);
    chk("t1_match_latency", 32'(t_match - t_start), 32'd7);
    chk("t1_pulses", 32'(pulses), 32'd1);
    chk("t1_count", 32'(done_cnt), 32'd1);

    // Overlap vs non-overlap.
    begin_job(5'b11011, 1);
    send_word(8'hDB, 1, 0);
    end_job();
    chk("ovl_pulses", 32'(pulses), 32'd2);
    chk("ovl_count", 32'(done_cnt), 32'd2);
    begin_job(5'b11011, 0);
    send_word(8'hDB, 1, 0);
    end_job();
    chk("novl_pulses", 32'(pulses), 32'd1);
    chk("novl_count", 32'(done_cnt), 32'd1);

    // Pattern straddling two words.
    begin_job(5'b10011, 0);
    send_word(8'h01, 0, 0);
    send_word(8'h38, 1, 0);
    end_job();
    chk("xword_pulses", 32'(pulses), 32'd1);
    chk("xword_match_latency", 32'(t_match - t_start), 32'd15);
    chk("xword_count", 32'(done_cnt), 32'd1);

    // Producer stall of 10 cycles between the two halves of the pattern.
    begin_job(5'b10011, 0);
    send_word(8'h01, 0, 0);
    send_word(8'h38, 1, 10);
    end_job();
    chk("stall_pulses", 32'(pulses), 32'd1);
    chk("stall_count", 32'(done_cnt), 32'd1);

    // Saturation of the 2-bit counter.
    begin_job(5'b10011, 0);
    for (int i = 0; i < 5; i++) send_word(8'h99, i == 4, 0);
    end_job();
    chk("sat_pulses", 32'(pulses), 32'd5);
    chk("sat_count8", 32'(done_cnt), 32'd5);
    chk("sat_count2", 32'(done_cnt2), 32'd3);

    // Asynchronous reset in the middle of a word.
    begin_job(5'b10011, 0);
    send_word(8'h99, 0, 0);
    send_word(8'hFF, 0, 0);
    repeat (3) @(posedge clk);
    #2 rst = 0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_bit_valid", 32'(bit_valid), 0);
    chk("mid_rst_bit_out", 32'(bit_out), 0);
    chk("mid_rst_match", 32'(match), 0);
    chk("mid_rst_match_count", 32'(match_count), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    @(posedge clk); #1 rst = 1;
    repeat (3) @(posedge clk);
    begin_job(5'b10011, 0);
    chk("post_rst_count", 32'(match_count), 0);
    send_word(8'h99, 1, 0);
    end_job();
    chk("post_rst_pulses", 32'(pulses), 32'd1);
    chk("post_rst_final", 32'(done_cnt), 32'd1);

    // Random jobs.
    for (int j = 0; j < 30; j++) begin
      int nw;
      logic [PAT_W-1:0] p;
      nw = $urandom_range(1, 4);
      p  = PAT_W'($urandom);
      begin_job(p, 1'($urandom));
      for (int wi = 0; wi < nw; wi++) begin
        // Half the words embed the pattern to make hits common.
        if ($urandom_range(0, 1) == 1)
          send_word(DATA_W'({p, 3'($urandom)}) , wi == nw - 1, $urandom_range(0, 3));
        else
          send_word(DATA_W'($urandom), wi == nw - 1, $urandom_range(0, 3));
      end
      end_job();
      chk("rand_count_vs_pulses", 32'(done_cnt), 32'(pulses));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
